multicycle_control_unit: RTL

Multi-cycle sequencer for the CPU datapath. It replaces single-cycle decoding with an FSM that steps each instruction through IF/ID/EX/MEM/WB. It waits on instruction and data memory ready handshakes, and issues per-state write enables and mux selects to the PC, IR, register file, ALU and data memory. It sits between the IR outputs (op/func), the comparator (rsrtequ) and the datapath control inputs.

---
 rtl/mcu_pkg.sv | 47 ++++
 rtl/mcu_decode.sv | 60 ++++++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, function codes,
// ALU and PC-source selects, FSM state and instruction-class enums.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001010;
    localparam logic [5:0] OP_LOAD  = 6'b001101;
    localparam logic [5:0] OP_STORE = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b001111;
    localparam logic [5:0] OP_BNE   = 6'b010000;
    localparam logic [5:0] OP_JUMP  = 6'b010010;

    localparam logic [5:0] FN_ADD = 6'b000001;
    localparam logic [5:0] FN_SUB = 6'b000010;
    localparam logic [5:0] FN_AND = 6'b000011;
    localparam logic [5:0] FN_OR  = 6'b000100;
    localparam logic [5:0] FN_SLL = 6'b000101;
    localparam logic [5:0] FN_SRL = 6'b000110;
    localparam logic [5:0] FN_SRA = 6'b000111;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLL = 3'b100;
    localparam logic [2:0] ALUC_SRL = 3'b101;
    localparam logic [2:0] ALUC_SRA = 3'b111;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ST_IF  = 3'b000,
        ST_ID  = 3'b001,
        ST_EX  = 3'b010,
        ST_MEM = 3'b011,
        ST_WB  = 3'b100
    } state_e;

    typedef enum logic [2:0] {
        R_ALU, I_ALU, LOAD, STORE, BEQ, BNE, JUMP, ILLEGAL
    } iclass_e;

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decoder: op/func to instruction class and the
// ALU/operand control fields that the FSM latches at the end of ID.
module mcu_decode
    import mcu_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output iclass_e    cls_o,
    output logic [2:0] aluc_o,
    output logic       aluimm_o,
    output logic       sext_o,
    output logic       shift_o,
    output logic       regrt_o
);

    always_comb begin
        cls_o    = ILLEGAL;
        aluc_o   = ALUC_ADD;
        aluimm_o = 1'b0;
        sext_o   = 1'b0;
        shift_o  = 1'b0;
        regrt_o  = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                cls_o = R_ALU;
                case (func_i)
                    FN_ADD: aluc_o = ALUC_ADD;
                    FN_SUB: aluc_o = ALUC_SUB;
                    FN_AND: aluc_o = ALUC_AND;
                    FN_OR:  aluc_o = ALUC_OR;
                    FN_SLL: begin aluc_o = ALUC_SLL; shift_o = 1'b1; end
                    FN_SRL: begin aluc_o = ALUC_SRL; shift_o = 1'b1; end
                    FN_SRA: begin aluc_o = ALUC_SRA; shift_o = 1'b1; end
                    default: cls_o = ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                cls_o = I_ALU; aluc_o = ALUC_ADD; aluimm_o = 1'b1; sext_o = 1'b1; regrt_o = 1'b1;
            end
            OP_ANDI: begin
                cls_o = I_ALU; aluc_o = ALUC_AND; aluimm_o = 1'b1; regrt_o = 1'b1;
            end
            OP_ORI: begin
                cls_o = I_ALU; aluc_o = ALUC_OR; aluimm_o = 1'b1; regrt_o = 1'b1;
            end
            // Loads and stores compute base + sign-extended offset.
            OP_LOAD: begin
                cls_o = LOAD; aluimm_o = 1'b1; sext_o = 1'b1; regrt_o = 1'b1;
            end
            OP_STORE: begin
                cls_o = STORE; aluimm_o = 1'b1; sext_o = 1'b1;
            end
            OP_BEQ:  begin cls_o = BEQ; aluc_o = ALUC_SUB; end
            OP_BNE:  begin cls_o = BNE; aluc_o = ALUC_SUB; end
            OP_JUMP: cls_o = JUMP;
            default: cls_o = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: steps each instruction through the
// datapath, waits on memory handshakes and counts retired instructions.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [5:0]       op_i,
    input  logic [5:0]       func_i,
    input  logic             rsrtequ_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    output logic             pcwrite_o,
    output logic             irwrite_o,
    output logic             wreg_o,
    output logic             m2reg_o,
    output logic             wmem_o,
    output logic             dmem_req_o,
    output logic             regrt_o,
    output logic             aluimm_o,
    output logic             sext_o,
    output logic             shift_o,
    output logic [2:0]       aluc_o,
    output logic [1:0]       pcsource_o,
    output logic [2:0]       state_o,
    output logic             illegal_o,
    output logic             instr_done_o,
    output logic [CNT_W-1:0] retired_o
);

    state_e     state_q, state_d;
    iclass_e    cls_q, dec_cls;
    logic [2:0] aluc_q, dec_aluc;
    logic       aluimm_q, sext_q, shift_q, regrt_q;
    logic       dec_aluimm, dec_sext, dec_shift, dec_regrt;
    logic       br_taken;
    logic [CNT_W-1:0] retired_q;

    mcu_decode u_decode (
        .op_i     (op_i),
        .func_i   (func_i),
        .cls_o    (dec_cls),
        .aluc_o   (dec_aluc),
        .aluimm_o (dec_aluimm),
        .sext_o   (dec_sext),
        .shift_o  (dec_shift),
        .regrt_o  (dec_regrt)
    );

    assign br_taken  = (cls_q == BEQ && rsrtequ_i) || (cls_q == BNE && !rsrtequ_i);
    assign state_o   = state_q;
    assign retired_o = retired_q;

    always_comb begin
        state_d      = state_q;
        pcwrite_o    = 1'b0;
        irwrite_o    = 1'b0;
        wreg_o       = 1'b0;
        m2reg_o      = 1'b0;
        wmem_o       = 1'b0;
        dmem_req_o   = 1'b0;
        regrt_o      = 1'b0;
        aluimm_o     = 1'b0;
        sext_o       = 1'b0;
        shift_o      = 1'b0;
        aluc_o       = ALUC_ADD;
        pcsource_o   = PCSRC_PC4;
        illegal_o    = 1'b0;
        instr_done_o = 1'b0;
        case (state_q)
            ST_IF: begin
                if (imem_ready_i) begin
                    irwrite_o = 1'b1;
                    pcwrite_o = 1'b1;
                    state_d   = ST_ID;
                end
            end
            ST_ID: begin
                if (dec_cls == JUMP) begin
                    pcwrite_o    = 1'b1;
                    pcsource_o   = PCSRC_JUMP;
                    instr_done_o = 1'b1;
                    state_d      = ST_IF;
                end else if (dec_cls == ILLEGAL) begin
                    illegal_o = 1'b1;
                    state_d   = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                aluc_o   = aluc_q;
                aluimm_o = aluimm_q;
                sext_o   = sext_q;
                shift_o  = shift_q;
                case (cls_q)
                    R_ALU, I_ALU: state_d = ST_WB;
                    LOAD, STORE:  state_d = ST_MEM;
                    BEQ, BNE: begin
                        if (br_taken) begin
                            pcwrite_o  = 1'b1;
                            pcsource_o = PCSRC_BRANCH;
                        end
                        instr_done_o = 1'b1;
                        state_d      = ST_IF;
                    end
                    default: state_d = ST_IF;
                endcase
            end
            // Memory stalls keep the request (and store strobe) asserted.
            ST_MEM: begin
                dmem_req_o = 1'b1;
                wmem_o     = (cls_q == STORE);
                if (dmem_ready_i) begin
                    if (cls_q == STORE) begin
                        instr_done_o = 1'b1;
                        state_d      = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                wreg_o       = 1'b1;
                m2reg_o      = (cls_q == LOAD);
                regrt_o      = regrt_q;
                instr_done_o = 1'b1;
                state_d      = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
        if (!rst_n_i) begin
            pcwrite_o    = 1'b0;
            irwrite_o    = 1'b0;
            wreg_o       = 1'b0;
            wmem_o       = 1'b0;
            dmem_req_o   = 1'b0;
            illegal_o    = 1'b0;
            instr_done_o = 1'b0;
        end
    end

    // Decode fields are captured only while in ID so later op/func changes are ignored.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IF;
            retired_q <= '0;
            cls_q     <= ILLEGAL;
            aluc_q    <= ALUC_ADD;
            aluimm_q  <= 1'b0;
            sext_q    <= 1'b0;
            shift_q   <= 1'b0;
            regrt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_done_o) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (state_q == ST_ID) begin
                cls_q    <= dec_cls;
                aluc_q   <= dec_aluc;
                aluimm_q <= dec_aluimm;
                sext_q   <= dec_sext;
                shift_q  <= dec_shift;
                regrt_q  <= dec_regrt;
            end
        end
    end

endmodule
